multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the Phase1 single-ALU datapath.
- Each instruction is run through FETCH, DECODE, EXEC and WB.
- Issues a fetch request/acknowledge handshake to instruction memory, decodes Opcode/Func, and drives the ALU/register-file control lines.
- Counts retired and illegal instructions; sits between instruction memory, the IR/PC registers and the datapath.

---
 rtl/multicycle_pkg.sv | 30 +++
 rtl/multicycle_ctrl_insn_decode.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the Phase1 multi-cycle control: sequencer states,
// instruction field encodings and ALU operation codes.
package multicycle_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        ILL    = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0011;

endpackage

// File: rtl/multicycle_ctrl_insn_decode.sv
// Purely combinational opcode/funct decoder. Shared between the multi-cycle
// sequencer and the single-cycle control, so it holds no state of its own.
module insn_decode
    import multicycle_pkg::*;
(
    input  logic [5:0] Opcode,
    input  logic [5:0] Func,
    output logic       ALUSrc,
    output logic       RegDst,
    output logic [3:0] ALUControl,
    output logic       Legal
);

    // Map an Opcode/Func pair onto datapath controls; anything unknown is flagged illegal
    always_comb begin
        ALUSrc     = 1'b0;
        RegDst     = 1'b0;
        ALUControl = ALU_AND;
        Legal      = 1'b1;
        if (Opcode == OP_RTYPE) begin
            RegDst = 1'b1;
            ALUSrc = 1'b0;
            case (Func)
                FN_ADD:  ALUControl = ALU_ADD;
                FN_AND:  ALUControl = ALU_AND;
                FN_OR:   ALUControl = ALU_OR;
                FN_XOR:  ALUControl = ALU_XOR;
                default: Legal      = 1'b0;
            endcase
        end else begin
            RegDst = 1'b0;
            ALUSrc = 1'b1;
            case (Opcode)
                OP_ADDI: ALUControl = ALU_ADD;
                OP_ANDI: ALUControl = ALU_AND;
                OP_ORI:  ALUControl = ALU_OR;
                OP_XORI: ALUControl = ALU_XOR;
                default: Legal      = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the Phase1 single-ALU datapath. Walks each
// instruction through FETCH/DECODE/EXEC/WB (or ILL), drives the fetch
// handshake and datapath strobes, and counts retired/illegal instructions.
// Every output comes straight from a flop: the next output values are
// derived from the next state so they line up with the state they belong to.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int ILL_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Run,
    input  logic             IMemAck,
    input  logic [31:0]      Instr,
    output logic             IMemReq,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             RegDst,
    output logic             RegWrite,
    output logic [3:0]       ALUControl,
    output logic             Illegal,
    output logic             Busy,
    output logic [CNT_W-1:0] RetiredCnt,
    output logic [ILL_W-1:0] IllegalCnt
);

    state_t           state_q, state_d;
    logic [5:0]       opcode_q, opcode_d;
    logic [5:0]       func_q, func_d;
    logic             imemReq_q, imemReq_d;
    logic             irWrite_q, irWrite_d;
    logic             pcWrite_q, pcWrite_d;
    logic             regWrite_q, regWrite_d;
    logic             illegal_q, illegal_d;
    logic             busy_q, busy_d;
    logic             aluSrc_q, aluSrc_d;
    logic             regDst_q, regDst_d;
    logic [3:0]       aluCtl_q, aluCtl_d;
    logic [CNT_W-1:0] retiredCnt_q, retiredCnt_d;
    logic [ILL_W-1:0] illegalCnt_q, illegalCnt_d;

    logic             decAluSrc;
    logic             decRegDst;
    logic [3:0]       decAluCtl;
    logic             decLegal;

    // The middle instruction bits belong to the register fields, not to control
    logic             instrUnused;
    assign instrUnused = ^Instr[25:6];

    insn_decode uDecode (
        .Opcode     (opcode_q),
        .Func       (func_q),
        .ALUSrc     (decAluSrc),
        .RegDst     (decRegDst),
        .ALUControl (decAluCtl),
        .Legal      (decLegal)
    );

    // Next state, latched instruction fields, next registered outputs and counters
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        func_d       = func_q;
        aluSrc_d     = aluSrc_q;
        regDst_d     = regDst_q;
        aluCtl_d     = aluCtl_q;
        retiredCnt_d = retiredCnt_q;
        illegalCnt_d = illegalCnt_q;

        case (state_q)
            IDLE: begin
                if (Run) state_d = FETCH;
            end
            FETCH: begin
                if (IMemAck) begin
                    opcode_d = Instr[31:26];
                    func_d   = Instr[5:0];
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (decLegal) begin
                    state_d  = EXEC;
                    aluSrc_d = decAluSrc;
                    regDst_d = decRegDst;
                    aluCtl_d = decAluCtl;
                end else begin
                    state_d = ILL;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB, ILL: begin
                state_d = Run ? FETCH : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        imemReq_d  = (state_d == FETCH);
        irWrite_d  = (state_d == DECODE);
        regWrite_d = (state_d == WB);
        illegal_d  = (state_d == ILL);
        pcWrite_d  = (state_d == WB) || (state_d == ILL);
        busy_d     = (state_d != IDLE);

        if (state_d == WB) begin
            retiredCnt_d = retiredCnt_q + CNT_W'(1);
        end
        if ((state_d == ILL) && (illegalCnt_q != {ILL_W{1'b1}})) begin
            illegalCnt_d = illegalCnt_q + ILL_W'(1);
        end
    end

    // State, outputs and counters; reset wins over everything, including a pending ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            opcode_q     <= 6'd0;
            func_q       <= 6'd0;
            imemReq_q    <= 1'b0;
            irWrite_q    <= 1'b0;
            pcWrite_q    <= 1'b0;
            regWrite_q   <= 1'b0;
            illegal_q    <= 1'b0;
            busy_q       <= 1'b0;
            aluSrc_q     <= 1'b0;
            regDst_q     <= 1'b0;
            aluCtl_q     <= 4'b0000;
            retiredCnt_q <= '0;
            illegalCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            func_q       <= func_d;
            imemReq_q    <= imemReq_d;
            irWrite_q    <= irWrite_d;
            pcWrite_q    <= pcWrite_d;
            regWrite_q   <= regWrite_d;
            illegal_q    <= illegal_d;
            busy_q       <= busy_d;
            aluSrc_q     <= aluSrc_d;
            regDst_q     <= regDst_d;
            aluCtl_q     <= aluCtl_d;
            retiredCnt_q <= retiredCnt_d;
            illegalCnt_q <= illegalCnt_d;
        end
    end

    assign IMemReq    = imemReq_q;
    assign IRWrite    = irWrite_q;
    assign PCWrite    = pcWrite_q;
    assign RegWrite   = regWrite_q;
    assign Illegal    = illegal_q;
    assign Busy       = busy_q;
    assign ALUSrc     = aluSrc_q;
    assign RegDst     = regDst_q;
    assign ALUControl = aluCtl_q;
    assign RetiredCnt = retiredCnt_q;
    assign IllegalCnt = illegalCnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized bench for multicycle_ctrl. A 4-bit retired counter
// is used so that wrap-around is reachable in a short run.
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int ILL_W = 8;
    localparam int ILL_MAX = (1 << ILL_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             Run;
    logic             IMemAck;
    logic [31:0]      Instr;
    logic             IMemReq;
    logic             IRWrite;
    logic             PCWrite;
    logic             ALUSrc;
    logic             RegDst;
    logic             RegWrite;
    logic [3:0]       ALUControl;
    logic             Illegal;
    logic             Busy;
    logic [CNT_W-1:0] RetiredCnt;
    logic [ILL_W-1:0] IllegalCnt;

    int total = 0;
    int bad = 0;

    int         expRetired;
    int         expIllegal;
    logic [3:0] expAluCtl;
    logic       expAluSrc;
    logic       expRegDst;

    multicycle_ctrl #(.CNT_W(CNT_W), .ILL_W(ILL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Run        (Run),
        .IMemAck    (IMemAck),
        .Instr      (Instr),
        .IMemReq    (IMemReq),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .ALUSrc     (ALUSrc),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl),
        .Illegal    (Illegal),
        .Busy       (Busy),
        .RetiredCnt (RetiredCnt),
        .IllegalCnt (IllegalCnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Instruction set as a lookup: R-type funct table and I-type opcode table
    function automatic void refDecode(input logic [31:0] ins, output logic legal,
                                      output logic [3:0] ctl, output logic src,
                                      output logic dst);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        legal = 1'b1;
        ctl = 4'b0000;
        if (op == 6'h00) begin
            src = 1'b0;
            dst = 1'b1;
            case (fn)
                6'h20:   ctl = 4'b0010;
                6'h24:   ctl = 4'b0000;
                6'h25:   ctl = 4'b0001;
                6'h26:   ctl = 4'b0011;
                default: legal = 1'b0;
            endcase
        end else begin
            src = 1'b1;
            dst = 1'b0;
            case (op)
                6'h08:   ctl = 4'b0010;
                6'h0C:   ctl = 4'b0000;
                6'h0D:   ctl = 4'b0001;
                6'h0E:   ctl = 4'b0011;
                default: legal = 1'b0;
            endcase
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkSignal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string phase, input logic req, input logic irw,
                               input logic pcw, input logic rw, input logic ill,
                               input logic busy);
        checkSignal({phase, ".IMemReq"}, 32'(IMemReq), 32'(req));
        checkSignal({phase, ".IRWrite"}, 32'(IRWrite), 32'(irw));
        checkSignal({phase, ".PCWrite"}, 32'(PCWrite), 32'(pcw));
        checkSignal({phase, ".RegWrite"}, 32'(RegWrite), 32'(rw));
        checkSignal({phase, ".Illegal"}, 32'(Illegal), 32'(ill));
        checkSignal({phase, ".Busy"}, 32'(Busy), 32'(busy));
        checkSignal({phase, ".ALUControl"}, 32'(ALUControl), 32'(expAluCtl));
        checkSignal({phase, ".ALUSrc"}, 32'(ALUSrc), 32'(expAluSrc));
        checkSignal({phase, ".RegDst"}, 32'(RegDst), 32'(expRegDst));
        checkSignal({phase, ".RetiredCnt"}, 32'(RetiredCnt), 32'(expRetired));
        checkSignal({phase, ".IllegalCnt"}, 32'(IllegalCnt), 32'(expIllegal));
    endtask

    task automatic modelReset();
        expRetired = 0;
        expIllegal = 0;
        expAluCtl  = 4'b0000;
        expAluSrc  = 1'b0;
        expRegDst  = 1'b0;
    endtask

    // One instruction from FETCH entry to WB/ILL; Run is raised on entry and
    // set to runAfter once decode is done, so it decides what follows WB/ILL
    task automatic applyStimulus(input logic [31:0] ins, input int ackDelay, input logic runAfter);
        logic       legal;
        logic [3:0] ctl;
        logic       src;
        logic       dst;
        refDecode(ins, legal, ctl, src, dst);
        Run = 1'b1;
        Instr = $urandom;
        IMemAck = 1'($urandom % 2);
        step();
        checkOutput("fetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= ackDelay; i++) begin
            IMemAck = (i == ackDelay);
            Run = (i == ackDelay) ? 1'b1 : 1'($urandom % 2);
            Instr = (i == ackDelay) ? ins : $urandom;
            step();
            if (i < ackDelay) checkOutput("fetchWait", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("decode", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        IMemAck = 1'($urandom % 2);
        Instr = $urandom;
        Run = runAfter;
        step();
        if (legal) begin
            expAluCtl = ctl;
            expAluSrc = src;
            expRegDst = dst;
            checkOutput("exec", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            step();
            expRetired = (expRetired + 1) % (1 << CNT_W);
            checkOutput("wb", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        end else begin
            if (expIllegal < ILL_MAX) expIllegal++;
            checkOutput("ill", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
    endtask

    function automatic logic [31:0] randomInstr();
        logic [31:0] ins;
        logic [5:0]  op;
        logic [5:0]  fn;
        ins = $urandom;
        case ($urandom % 6)
            0:       op = 6'h00;
            1:       op = 6'h08;
            2:       op = 6'h0C;
            3:       op = 6'h0D;
            4:       op = 6'h0E;
            default: op = 6'($urandom);
        endcase
        case ($urandom % 5)
            0:       fn = 6'h20;
            1:       fn = 6'h24;
            2:       fn = 6'h25;
            3:       fn = 6'h26;
            default: fn = 6'($urandom);
        endcase
        ins[31:26] = op;
        ins[5:0] = fn;
        return ins;
    endfunction

    // Directed scenarios followed by a randomized stream
    initial begin
        int          idleCycles;
        int          delay;
        logic        runAfter;
        $display("[TB] multicycle_ctrl bench starting");

        rst_n = 1'b0;
        Run = 1'b0;
        IMemAck = 1'b0;
        Instr = 32'h0;
        step();
        step();
        modelReset();
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        checkOutput("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(32'h00221820, 0, 1'b1);
        checkSignal("addRetired", 32'(RetiredCnt), 32'd1);
        applyStimulus(32'h3022000F, 3, 1'b1);

        for (int n = 0; n < 260; n++) begin
            applyStimulus(32'h0022182A, 0, 1'b1);
        end
        checkSignal("illSaturated", 32'(IllegalCnt), 32'd255);
        checkSignal("illRetiredKept", 32'(RetiredCnt), 32'd2);

        applyStimulus(32'h3422000F, 1, 1'b0);
        step();
        checkOutput("idleAfterOri", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 17; n++) begin
            applyStimulus(32'h00221826, 0, 1'b1);
        end
        checkSignal("xorWrapped", 32'(RetiredCnt), 32'd4);

        for (int n = 0; n < 40; n++) begin
            delay = int'($urandom % 4);
            runAfter = (($urandom % 4) != 0);
            applyStimulus(randomInstr(), delay, runAfter);
            if (!runAfter) begin
                idleCycles = 1 + int'($urandom % 3);
                for (int k = 0; k < idleCycles; k++) begin
                    IMemAck = 1'($urandom % 2);
                    step();
                    checkOutput("randIdle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            end
        end

        Run = 1'b1;
        Instr = 32'h00221820;
        IMemAck = 1'b0;
        step();
        checkOutput("preRstFetch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        IMemAck = 1'b1;
        step();
        modelReset();
        checkOutput("rstInFetch", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        Run = 1'b0;
        step();
        checkOutput("idleAfterRst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
